// File: rtl/clk_div_monitor.sv
`timescale 1ns/1ps
// clk_div_monitor: measures period and high time of a clk-derived divided clock at
// half-cycle resolution (sampled on both clk edges) and reports error/lock/stuck.
//
//  state        | meaning
//  S_IDLE       | disabled; counters cleared, lock/stuck low, results held
//  S_WAIT_FIRST | waiting for the first rise to start counting
//  S_MEASURE    | counting half-cycles between consecutive rises
module clk_div_monitor #(
  parameter int EXP_DIV    = 7,
  parameter int CHECK_DUTY = 1,
  parameter int LOCK_N     = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_clk_in,
  output logic [CNT_W-1:0] period_hc,
  output logic [CNT_W-1:0] high_hc,
  output logic             meas_valid,
  output logic             err,
  output logic             lock,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] GOOD_PER  = CNT_W'(2 * EXP_DIV);
  localparam logic [CNT_W-1:0] GOOD_HIGH = CNT_W'(EXP_DIV);
  localparam logic [3:0]       LOCK_CNT  = 4'(LOCK_N);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_FIRST, S_MEASURE} state_t;

  state_t           state_q, state_d;
  logic             pos_s_q, neg_s_q, last_s_q;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             err_q, err_d;
  logic             lock_q, lock_d;
  logic             stuck_q, stuck_d;

  logic             rise_pos, rise_neg, rise;
  logic [CNT_W-1:0] meas_per, start_per, start_high, per_next, high_next;
  logic             good;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  // Falling-edge sample gives the second half-cycle of each clk period.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) neg_s_q <= 1'b0;
    else      neg_s_q <= div_clk_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_s_q  <= 1'b0;
      last_s_q <= 1'b0;
    end else begin
      pos_s_q  <= div_clk_in;
      last_s_q <= neg_s_q;
    end
  end

  assign rise_pos = pos_s_q & ~last_s_q;
  assign rise_neg = neg_s_q & ~pos_s_q;
  assign rise     = rise_pos | rise_neg;

  // On a neg-sample rise the pos sample (a 0) still belongs to the closing period.
  assign meas_per   = rise_pos ? per_cnt_q : sat_add(per_cnt_q, 2'd1);
  assign start_per  = rise_pos ? CNT_W'(2) : CNT_W'(1);
  assign start_high = (rise_pos && neg_s_q) ? CNT_W'(2) : CNT_W'(1);
  assign per_next   = sat_add(per_cnt_q, 2'd2);
  assign high_next  = sat_add(high_cnt_q, {1'b0, pos_s_q} + {1'b0, neg_s_q});
  assign good       = (meas_per == GOOD_PER) && ((CHECK_DUTY == 0) || (high_cnt_q == GOOD_HIGH));

  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    high_cnt_d   = high_cnt_q;
    period_d     = period_q;
    high_d       = high_q;
    good_cnt_d   = good_cnt_q;
    meas_valid_d = 1'b0;
    err_d        = 1'b0;
    lock_d       = lock_q;
    stuck_d      = stuck_q;
    if (!en) begin
      state_d    = S_IDLE;
      per_cnt_d  = '0;
      high_cnt_d = '0;
      good_cnt_d = '0;
      lock_d     = 1'b0;
      stuck_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT_FIRST;
        S_WAIT_FIRST: begin
          if (rise) begin
            state_d    = S_MEASURE;
            per_cnt_d  = start_per;
            high_cnt_d = start_high;
            stuck_d    = 1'b0;
          end
        end
        S_MEASURE: begin
          if (rise) begin
            per_cnt_d    = start_per;
            high_cnt_d   = start_high;
            period_d     = meas_per;
            high_d       = high_cnt_q;
            meas_valid_d = 1'b1;
            if (good) begin
              if (good_cnt_q != LOCK_CNT) good_cnt_d = good_cnt_q + 4'd1;
              lock_d = (good_cnt_d == LOCK_CNT);
            end else begin
              err_d      = 1'b1;
              good_cnt_d = '0;
              lock_d     = 1'b0;
            end
          end else if (per_next == CNT_MAX) begin
            state_d    = S_WAIT_FIRST;
            per_cnt_d  = '0;
            high_cnt_d = '0;
            good_cnt_d = '0;
            lock_d     = 1'b0;
            stuck_d    = 1'b1;
          end else begin
            per_cnt_d  = per_next;
            high_cnt_d = high_next;
          end
        end
        default: state_d = S_WAIT_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_WAIT_FIRST;
      per_cnt_q    <= '0;
      high_cnt_q   <= '0;
      period_q     <= '0;
      high_q       <= '0;
      good_cnt_q   <= '0;
      meas_valid_q <= 1'b0;
      err_q        <= 1'b0;
      lock_q       <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      high_cnt_q   <= high_cnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      good_cnt_q   <= good_cnt_d;
      meas_valid_q <= meas_valid_d;
      err_q        <= err_d;
      lock_q       <= lock_d;
      stuck_q      <= stuck_d;
    end
  end

  assign period_hc  = period_q;
  assign high_hc    = high_q;
  assign meas_valid = meas_valid_q;
  assign err        = err_q;
  assign lock       = lock_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
`timescale 1ns/1ps
// Bench for clk_div_monitor: two instances (duty checked / not checked) driven by the
// same divided clock; expectations come from a half-cycle sample history model.
module tb_clk_div_monitor;
  localparam int CNT_W  = 8;
  localparam int CMAX   = 255;
  localparam int LOCK_N = 4;
  localparam int SAMP_N = 40000;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, div_clk_in = 1'b0;
  logic [CNT_W-1:0] period_w [2];
  logic [CNT_W-1:0] high_w [2];
  logic mv_w [2], err_w [2], lock_w [2], stuck_w [2];

  clk_div_monitor #(.EXP_DIV(7), .CHECK_DUTY(1), .LOCK_N(LOCK_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .div_clk_in(div_clk_in),
    .period_hc(period_w[0]), .high_hc(high_w[0]), .meas_valid(mv_w[0]),
    .err(err_w[0]), .lock(lock_w[0]), .stuck(stuck_w[0]));

  clk_div_monitor #(.EXP_DIV(7), .CHECK_DUTY(0), .LOCK_N(LOCK_N), .CNT_W(CNT_W)) dut_nd (
    .clk(clk), .rst(rst), .en(en), .div_clk_in(div_clk_in),
    .period_hc(period_w[1]), .high_hc(high_w[1]), .meas_valid(mv_w[1]),
    .err(err_w[1]), .lock(lock_w[1]), .stuck(stuck_w[1]));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sampled divided-clock history, one entry per clk edge.
  bit samp [SAMP_N];
  int idx = 3;

  // Model state per instance (0: duty checked, 1: duty ignored).
  int m_idle [2], m_have [2], m_prev [2], m_gr [2];
  int e_mv [2], e_err [2], e_lock [2], e_stuck [2], e_per [2], e_hi [2];

  int gmode, gper, ghi, gph;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_idle[m] = 0; m_have[m] = 0; m_prev[m] = 0; m_gr[m] = 0;
      e_mv[m] = 0; e_err[m] = 0; e_lock[m] = 0; e_stuck[m] = 0; e_per[m] = 0; e_hi[m] = 0;
    end
  endtask

  // Rising clk edge at history index p: the two samples p-2 (rising) and p-1 (falling) are judged.
  task automatic model_posedge(input int p);
    int rise, per, hi;
    bit good;
    rise = -1;
    for (int k = p - 2; k <= p - 1; k++)
      if (rise < 0 && samp[k] && !samp[k-1]) rise = k;
    for (int m = 0; m < 2; m++) begin
      e_mv[m] = 0; e_err[m] = 0;
      if (!en) begin
        m_idle[m] = 1; m_have[m] = 0; m_gr[m] = 0; e_lock[m] = 0; e_stuck[m] = 0;
      end else if (m_idle[m] != 0) begin
        m_idle[m] = 0;
      end else if (rise >= 0) begin
        if (m_have[m] != 0) begin
          per = rise - m_prev[m];
          if (per > CMAX) per = CMAX;
          hi = 0;
          for (int k = m_prev[m]; k < rise; k++) hi += samp[k];
          if (hi > CMAX) hi = CMAX;
          e_mv[m] = 1; e_per[m] = per; e_hi[m] = hi;
          good = (per == 14) && (m == 1 || hi == 7);
          if (good) begin
            if (m_gr[m] < LOCK_N) m_gr[m]++;
            e_lock[m] = (m_gr[m] == LOCK_N);
          end else begin
            e_err[m] = 1; m_gr[m] = 0; e_lock[m] = 0;
          end
        end
        m_have[m] = 1; m_prev[m] = rise; e_stuck[m] = 0;
      end else if (m_have[m] != 0 && (p - m_prev[m]) >= CMAX) begin
        e_stuck[m] = 1; e_lock[m] = 0; m_gr[m] = 0; m_have[m] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("u%0d.meas_valid", m), int'(mv_w[m]), e_mv[m]);
      chk($sformatf("u%0d.err", m), int'(err_w[m]), e_err[m]);
      chk($sformatf("u%0d.lock", m), int'(lock_w[m]), e_lock[m]);
      chk($sformatf("u%0d.stuck", m), int'(stuck_w[m]), e_stuck[m]);
      chk($sformatf("u%0d.period_hc", m), int'(period_w[m]), e_per[m]);
      chk($sformatf("u%0d.high_hc", m), int'(high_w[m]), e_hi[m]);
    end
  endtask

  task automatic pick_random();
    if ($urandom_range(0, 1) == 1) begin
      gper = 14; ghi = 7;
    end else begin
      gper = int'($urandom_range(2, 40));
      ghi  = int'($urandom_range(1, gper - 1));
    end
  endtask

  task automatic set_gen(input int mode, input int per, input int hi);
    gmode = mode; gper = per; ghi = hi; gph = 0;
  endtask

  task automatic gen_next(output logic v);
    if (gmode == 1) v = 1'b0;
    else begin
      v = (gph < ghi);
      gph++;
      if (gph >= gper) begin
        gph = 0;
        if (gmode == 2) pick_random();
      end
    end
  endtask

  task automatic step();
    logic v;
    @(clk);
    #1;
    idx++;
    if (idx >= SAMP_N) begin
      $display("FAIL sample_budget: got %0d, expected < %0d", idx, SAMP_N);
      $fatal(1, "history exhausted");
    end
    samp[idx] = rst ? div_clk_in : 1'b0;
    if (clk) begin
      if (!rst) model_reset();
      else model_posedge(idx);
      compare_all();
    end
    gen_next(v);
    div_clk_in = v;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic sync_pos();
    step();
    while (!clk) step();
  endtask

  task automatic do_reset();
    sync_pos();
    rst = 1'b0;
    #1;
    model_reset();
    samp[idx] = 1'b0;
    samp[idx-1] = 1'b0;
    compare_all();
    run(4);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    model_reset();
    set_gen(0, 14, 7);
    run(5);
    rst = 1'b1;
    chk("rst.period_hc", int'(period_w[0]), 0);
    chk("rst.lock", int'(lock_w[0]), 0);

    en = 1'b1;
    run(14 * 9);
    chk("d7.lock", int'(lock_w[0]), 1);
    chk("d7.period", int'(period_w[0]), 14);
    chk("d7.high", int'(high_w[0]), 7);

    set_gen(0, 12, 6);
    run(12 * 8);
    chk("d6.lock", int'(lock_w[0]), 0);
    chk("d6.lock_nd", int'(lock_w[1]), 0);
    chk("d6.period", int'(period_w[0]), 12);

    set_gen(0, 14, 6);
    run(14 * 9);
    chk("duty.lock", int'(lock_w[0]), 0);
    chk("duty.high", int'(high_w[0]), 6);
    chk("duty.lock_nd", int'(lock_w[1]), 1);

    set_gen(0, 14, 7);
    run(14 * 9);
    set_gen(1, 0, 0);
    run(300);
    chk("stuck.stuck", int'(stuck_w[0]), 1);
    chk("stuck.lock", int'(lock_w[0]), 0);
    set_gen(0, 14, 7);
    run(14 * 9);
    chk("resume.stuck", int'(stuck_w[0]), 0);
    chk("resume.lock", int'(lock_w[0]), 1);

    do_reset();
    run(14 * 9);
    chk("postrst.lock", int'(lock_w[0]), 1);
    chk("postrst.period", int'(period_w[0]), 14);

    sync_pos();
    en = 1'b0;
    run(20);
    chk("idle.lock", int'(lock_w[0]), 0);
    chk("idle.period", int'(period_w[0]), 14);
    en = 1'b1;
    run(14 * 9);
    chk("reen.lock", int'(lock_w[0]), 1);

    gmode = 2; gph = 0; pick_random();
    for (int s = 0; s < 120; s++) begin
      run(int'($urandom_range(10, 80)));
      r = int'($urandom_range(0, 19));
      if (r < 3) begin
        en = 1'b0;
        run(int'($urandom_range(2, 30)));
        en = 1'b1;
      end else if (r == 3) begin
        do_reset();
      end else if (r == 4) begin
        gmode = 1;
        run(int'($urandom_range(200, 320)));
        gmode = 2; gph = 0; pick_random();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Measures a divided clock produced from clk by an on-chip frequency divider, such as the odd-ratio 50%-duty dividers that toggle on both clk edges.
- Samples the divided clock on both clk edges, giving half-cycle resolution.
- Reports period and high time in clk half-cycles and checks them against the expected division ratio.
- Asserts lock after consecutive good periods; sits beside each divider as its built-in checker.

Parameters:
- EXP_DIV, 7, expected division ratio; good period = 2*EXP_DIV half-cycles.
- CHECK_DUTY, 1, when 1 a good period also requires high time = EXP_DIV half-cycles (50%).
- LOCK_N, 4, consecutive good measurements required before lock asserts (range 1..15).
- CNT_W, 8, width of the half-cycle counters and result ports.

Ports:
- clk  input  1  reference clock; all outputs registered on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  measurement enable, synchronous to clk rising edge.
- div_clk_in  input  1  divided clock; derived from clk, so edges coincide with clk edges; no synchronizer.
- period_hc  output  CNT_W  last measured period in half-cycles.
- high_hc  output  CNT_W  last measured high time in half-cycles.
- meas_valid  output  1  one-cycle pulse when period_hc/high_hc update.
- err  output  1  one-cycle pulse, coincident with meas_valid, when the measurement is not good.
- lock  output  1  level; high after LOCK_N consecutive good measurements.
- stuck  output  1  level; high while no rising edge is seen for 2^CNT_W-1 half-cycles.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, all counters 0, sample flops 0, state WAIT_FIRST.
- Sampling:
  - pos_s captures div_clk_in on the clk rising edge; neg_s captures it on the clk falling edge.
  - On each rising edge the core processes the ordered pair (pos_s, neg_s), pos_s first, against last_s (the previous neg_s).
  - A rise is 0->1 between consecutive samples. At most one rise occurs per pair.
- Latency: outputs update on the first clk rising edge strictly after the clk edge (either polarity) that sampled the new high level.
- States:
  - IDLE: entered whenever en=0 (synchronous). Counters clear, lock=0, stuck=0. period_hc and high_hc hold.
  - en=1 moves IDLE to WAIT_FIRST.
  - WAIT_FIRST: waits for the first rise. That rise starts counting and moves to MEASURE. No meas_valid is produced.
  - MEASURE, on each subsequent rise:
    - period_hc = half-cycle samples from the previous rise (inclusive) to this rise (exclusive).
    - high_hc = number of those samples that were 1.
    - meas_valid pulses; counters restart with the samples at and after the rise.
    - If the rise is at pos_s, the new period starts with count 2 and high count 1+neg_s.
    - If the rise is at neg_s, the new period starts with count 1 and high count 1.
- Good measurement: period_hc == 2*EXP_DIV and (CHECK_DUTY==0 or high_hc == EXP_DIV).
  - Good: the good-run counter increments, saturating at LOCK_N. lock=1 once it reaches LOCK_N, in the same cycle as meas_valid.
  - Not good: err=1, good-run counter cleared, lock=0, all in the same cycle.
- Saturation and stuck:
  - Both counters saturate at 2^CNT_W-1.
  - When the period counter saturates: stuck=1, lock=0, good-run counter cleared, and the state returns to WAIT_FIRST.
  - No meas_valid or err is produced for a stuck period.
  - stuck clears on the next rise, which also restarts measurement as a first rise.
- Simultaneous events: en falling on the same cycle as a measurement completes means en wins; no meas_valid, go to IDLE. The rise that ends one period also starts the next; no sample is lost or double counted.
- Reset mid-measurement: everything clears immediately. The partial period is discarded, and the first rise after reset gives no meas_valid.

Test Plan:
- Divide-by-7, 50% duty (toggles at rising edge count 6 and falling edge count 3), en=1, defaults -> meas_valid every 7 cycles, period_hc=14, high_hc=7, err=0; lock=1 on the 4th meas_valid.
- Divide-by-6 (toggle every 3 rising edges) -> period_hc=12, high_hc=6, err pulses with every meas_valid, lock stays 0.
- Divide-by-7 with high time 6 half-cycles: CHECK_DUTY=1 -> period_hc=14, high_hc=6, err=1; CHECK_DUTY=0 -> err=0, lock after 4.
- Locked, then div_clk_in held low -> 255 half-cycles (CNT_W=8) after the last rise: stuck=1, lock=0, no meas_valid. Resume divide-by-7 -> stuck=0 at the first rise; first meas_valid one period later; lock after 4 more.
- rst pulsed low mid-period while locked -> outputs 0 immediately. After release: first rise gives no meas_valid; the next gives period_hc=14.
- en dropped while locked, raised 10 cycles later -> lock=0 during IDLE, period_hc holds 14; re-lock after 1 discarded rise plus 4 good periods.
